// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Arbitrates a read-only ICache port and a read/write DCache
//               port onto a single memory-controller request channel.
//               At most one transaction is outstanding. Simultaneous
//               requests are granted round-robin. All memory-side outputs
//               are registered at the grant edge.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // ICache port (read only)
    input  logic [1:0]            i_rw_flag,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  i_busy,
    output logic                  i_done,

    // DCache port
    input  logic [1:0]            d_rw_flag,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [3:0]            d_write_mask,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  d_busy,
    output logic                  d_done,

    // Memory-controller channel
    output logic [1:0]            mem_rw_flag,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [3:0]            mem_write_mask,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2
    } state_t;

    localparam logic [1:0] c_RW_IDLE  = 2'b00;
    localparam logic [1:0] c_RW_READ  = 2'b01;
    localparam logic [1:0] c_RW_WRITE = 2'b10;

    state_t r_state;
    // Set when the most recent grant went to the DCache; cleared by reset
    // so that the DCache wins the first conflict.
    logic   r_last_d;

    logic   w_i_valid;
    logic   w_d_valid;
    logic   w_grant_d;

    // Request decode: the ICache upper flag bit is ignored, DCache 11 is idle.
    assign w_i_valid = i_rw_flag[0];
    assign w_d_valid = (d_rw_flag == c_RW_READ) || (d_rw_flag == c_RW_WRITE);
    // DCache wins when alone, or on a conflict when ICache was granted last.
    assign w_grant_d = w_d_valid && (!w_i_valid || !r_last_d);

    // Arbitration FSM with registered memory request and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_last_d       <= 1'b0;
            mem_rw_flag    <= c_RW_IDLE;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= 4'b0000;
            i_read_data    <= '0;
            d_read_data    <= '0;
            i_busy         <= 1'b0;
            d_busy         <= 1'b0;
            i_done         <= 1'b0;
            d_done         <= 1'b0;
        end else begin
            // Done flags are single-cycle pulses.
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= S_SERVE_D;
                        r_last_d       <= 1'b1;
                        mem_rw_flag    <= d_rw_flag;
                        mem_addr       <= d_addr;
                        mem_write_data <= d_write_data;
                        mem_write_mask <= d_write_mask;
                        d_busy         <= 1'b1;
                    end else if (w_i_valid) begin
                        r_state        <= S_SERVE_I;
                        r_last_d       <= 1'b0;
                        mem_rw_flag    <= c_RW_READ;
                        mem_addr       <= i_addr;
                        mem_write_data <= '0;
                        mem_write_mask <= 4'b0000;
                        i_busy         <= 1'b1;
                    end
                end
                S_SERVE_I: begin
                    if (mem_done) begin
                        r_state     <= S_IDLE;
                        mem_rw_flag <= c_RW_IDLE;
                        i_read_data <= mem_read_data;
                        i_done      <= 1'b1;
                        i_busy      <= 1'b0;
                    end
                end
                S_SERVE_D: begin
                    if (mem_done) begin
                        r_state     <= S_IDLE;
                        mem_rw_flag <= c_RW_IDLE;
                        // Writes return no data; keep the last read value.
                        if (mem_rw_flag == c_RW_READ) begin
                            d_read_data <= mem_read_data;
                        end
                        d_done      <= 1'b1;
                        d_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    mem_rw_flag <= c_RW_IDLE;
                    i_busy      <= 1'b0;
                    d_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Self-checking bench for cache_mem_arbiter. Drives both cache
//               ports and acts as the memory controller; a transaction-level
//               model predicts the grant order and returned data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    i_rw_flag;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_read_data;
    logic          i_busy;
    logic          i_done;
    logic [1:0]    d_rw_flag;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_write_data;
    logic [3:0]    d_write_mask;
    logic [DW-1:0] d_read_data;
    logic          d_busy;
    logic          d_done;
    logic [1:0]    mem_rw_flag;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic [3:0]    mem_write_mask;
    logic [DW-1:0] mem_read_data;
    logic          mem_done;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rw_flag      (i_rw_flag),
        .i_addr         (i_addr),
        .i_read_data    (i_read_data),
        .i_busy         (i_busy),
        .i_done         (i_done),
        .d_rw_flag      (d_rw_flag),
        .d_addr         (d_addr),
        .d_write_data   (d_write_data),
        .d_write_mask   (d_write_mask),
        .d_read_data    (d_read_data),
        .d_busy         (d_busy),
        .d_done         (d_done),
        .mem_rw_flag    (mem_rw_flag),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_mask (mem_write_mask),
        .mem_read_data  (mem_read_data),
        .mem_done       (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level).
    bit            last_d;     // most recent grant went to DCache
    bit            pend_i;
    bit            pend_d;
    logic [DW-1:0] exp_i_data;
    logic [DW-1:0] exp_d_data;
    int            n_grant_d;
    int            n_grant_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".mem_rw"}, 64'(mem_rw_flag), 64'd0);
        chk({tag, ".i_busy"}, 64'(i_busy), 64'd0);
        chk({tag, ".d_busy"}, 64'(d_busy), 64'd0);
        chk({tag, ".i_done"}, 64'(i_done), 64'd0);
        chk({tag, ".d_done"}, 64'(d_done), 64'd0);
    endtask

    task automatic new_i_req(input logic [AW-1:0] a);
        pend_i    = 1'b1;
        i_addr    = a;
        i_rw_flag = {1'($urandom_range(0, 1)), 1'b1};
    endtask

    task automatic new_d_req(input logic [1:0] f, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [3:0] wm);
        pend_d       = 1'b1;
        d_rw_flag    = f;
        d_addr       = a;
        d_write_data = wd;
        d_write_mask = wm;
    endtask

    // One arbitrated transaction. Called at a negedge in IDLE with the
    // pending requests already driven; returns at the negedge after done.
    task automatic run_txn(input int lat, input bit allow_drop);
        bit            win_d;
        logic [1:0]    e_flag;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [3:0]    e_wm;
        logic [DW-1:0] rdata;
        win_d  = pend_d && (!pend_i || !last_d);
        e_flag = win_d ? d_rw_flag : 2'b01;
        e_addr = win_d ? d_addr : i_addr;
        e_wd   = win_d ? d_write_data : '0;
        e_wm   = win_d ? d_write_mask : 4'b0000;
        last_d = win_d;
        if (win_d) n_grant_d++; else n_grant_i++;
        @(negedge clk);
        chk("grant.mem_rw", 64'(mem_rw_flag), 64'(e_flag));
        chk("grant.mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("grant.mem_wd", 64'(mem_write_data), 64'(e_wd));
        chk("grant.mem_wm", 64'(mem_write_mask), 64'(e_wm));
        chk("grant.i_busy", 64'(i_busy), 64'(!win_d));
        chk("grant.d_busy", 64'(d_busy), 64'(win_d));
        chk("grant.i_done", 64'(i_done), 64'd0);
        chk("grant.d_done", 64'(d_done), 64'd0);
        for (int k = 1; k < lat; k++) begin
            // The winner may abandon its request; the transaction must go on.
            if (allow_drop && $urandom_range(0, 3) == 0) begin
                if (win_d) d_rw_flag = 2'b00; else i_rw_flag = 2'b00;
            end
            @(negedge clk);
            chk("wait.mem_rw", 64'(mem_rw_flag), 64'(e_flag));
            chk("wait.busy", 64'({i_busy, d_busy}), win_d ? 64'd1 : 64'd2);
        end
        rdata         = $urandom;
        mem_read_data = rdata;
        mem_done      = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        if (win_d) begin
            if (e_flag == 2'b01) exp_d_data = rdata;
        end else begin
            exp_i_data = rdata;
        end
        chk("done.i_done", 64'(i_done), 64'(!win_d));
        chk("done.d_done", 64'(d_done), 64'(win_d));
        chk("done.i_data", 64'(i_read_data), 64'(exp_i_data));
        chk("done.d_data", 64'(d_read_data), 64'(exp_d_data));
        chk("done.mem_rw", 64'(mem_rw_flag), 64'd0);
        chk("done.busy", 64'({i_busy, d_busy}), 64'd0);
        // Winner releases its request once it has seen done.
        if (win_d) begin
            pend_d    = 1'b0;
            d_rw_flag = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        end else begin
            pend_i    = 1'b0;
            i_rw_flag = {1'($urandom_range(0, 1)), 1'b0};
        end
    endtask

    initial begin
        rst           = 1'b0;
        i_rw_flag     = 2'b00;
        i_addr        = '0;
        d_rw_flag     = 2'b00;
        d_addr        = '0;
        d_write_data  = '0;
        d_write_mask  = 4'b0000;
        mem_read_data = '0;
        mem_done      = 1'b0;
        last_d        = 1'b0;
        pend_i        = 1'b0;
        pend_d        = 1'b0;
        exp_i_data    = '0;
        exp_d_data    = '0;
        n_grant_d     = 0;
        n_grant_i     = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset.mem_addr", 64'(mem_addr), 64'd0);
        chk("reset.mem_wm", 64'(mem_write_mask), 64'd0);
        chk("reset.i_data", 64'(i_read_data), 64'd0);
        chk("reset.d_data", 64'(d_read_data), 64'd0);
        rst = 1'b1;

        // ICache-only read, three-cycle latency
        new_i_req(32'h100);
        run_txn(3, 1'b0);

        // Simultaneous requests: DCache write goes first, then ICache
        // (last grant was ICache).
        new_i_req(32'h200);
        new_d_req(2'b10, 32'h300, 32'h1234_5678, 4'b1111);
        run_txn(2, 1'b0);
        run_txn(2, 1'b0);

        // Stray mem_done in IDLE with DCache flag 11
        d_rw_flag = 2'b11;
        mem_done  = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk_idle_outputs("idle_done");
        @(negedge clk);
        chk_idle_outputs("idle_done2");

        // Reset in the middle of a DCache transaction
        new_d_req(2'b01, 32'h440, 32'h0, 4'b0000);
        @(negedge clk);
        chk("rstmid.d_busy", 64'(d_busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk_idle_outputs("rstmid");
        chk("rstmid.mem_addr", 64'(mem_addr), 64'd0);
        chk("rstmid.d_data", 64'(d_read_data), 64'd0);
        exp_i_data = '0;
        exp_d_data = '0;
        last_d     = 1'b0;
        mem_done   = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("rstmid.no_done", 64'(d_done), 64'd0);
        rst = 1'b1;
        new_i_req(32'h500);
        run_txn(1, 1'b0);   // DCache must win the first post-reset conflict

        // Randomized traffic; both ports held often so grants alternate.
        for (int t = 0; t < 60; t++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) new_i_req($urandom);
            if (!pend_d && $urandom_range(0, 2) != 0)
                new_d_req($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom, $urandom,
                          4'($urandom_range(0, 15)));
            if (!pend_i && !pend_d) new_i_req($urandom);
            run_txn(int'($urandom_range(1, 5)), 1'b1);
        end

        chk("grant_mix", 64'((n_grant_d > 5) && (n_grant_i > 5)), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rw_flag  in  2  ICache request; [0] read, [1] ignored (read-only port), 00 idle.
REQ-006 SHALL have port i_addr  in  ADDR_WIDTH  ICache request address.
REQ-007 SHALL have ports i_read_data out DATA_WIDTH, i_busy out 1, i_done out 1: ICache response, busy flag, completion pulse.
REQ-008 SHALL have port d_rw_flag  in  2  DCache request; 01 read, 10 write, 00/11 idle.
REQ-009 SHALL have ports d_addr in ADDR_WIDTH, d_write_data in DATA_WIDTH, d_write_mask in 4: DCache request fields.
REQ-010 SHALL have ports d_read_data out DATA_WIDTH, d_busy out 1, d_done out 1: DCache response, busy flag, completion pulse.
REQ-011 SHALL have ports mem_rw_flag out 2, mem_addr out ADDR_WIDTH, mem_write_data out DATA_WIDTH, mem_write_mask out 4: memory-controller request.
REQ-012 SHALL have ports mem_read_data in DATA_WIDTH, mem_done in 1: memory response, one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; one memory transaction outstanding at most.
REQ-014 IDLE: sample requests each edge; valid request = i_rw_flag[0]=1, or d_rw_flag in {01,10}.
REQ-015 Exactly one valid request in IDLE -> next state SERVE_I or SERVE_D for that requester.
REQ-016 Both valid in IDLE -> grant the port not granted last (round-robin); first conflict after reset grants DCache.
REQ-017 On grant edge, SHALL register addr, write_data, write_mask and rw_flag (ICache always 01) of the winner; all mem_* outputs driven from these registers.
REQ-018 mem_rw_flag SHALL be nonzero only in SERVE_I/SERVE_D and held constant until mem_done; 00 in IDLE.
REQ-019 Latency: request valid before edge N in IDLE -> mem_rw_flag valid in cycle after edge N.
REQ-020 i_busy=1 while state=SERVE_I; d_busy=1 while state=SERVE_D; else 0.
REQ-021 mem_done=1 in SERVE_x -> on that edge capture mem_read_data into x_read_data, pulse x_done=1 for exactly one cycle, go to IDLE.
REQ-022 x_read_data SHALL hold last captured value until next completion on that port; writes leave d_read_data unchanged.
REQ-023 mem_done while IDLE SHALL be ignored (no done pulse, no state change).
REQ-024 Request dropped mid-transaction: transaction still completes and done pulses; requester changes ignored until IDLE.
REQ-025 After completion, the next grant occurs no earlier than the following IDLE edge (one bubble cycle); starvation bounded to one transaction by REQ-016.
REQ-026 Requesters SHALL hold rw_flag until done; a request still asserted in the done cycle is treated as a new request in IDLE.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, last-grant=ICache (so DCache wins first conflict), mem_rw_flag=00, mem_addr/mem_write_data=0, mem_write_mask=0, i_/d_read_data=0, all busy/done=0.
REQ-028 Reset mid-transaction SHALL abandon it: no done pulse; memory-controller rw_flag drops to 00 immediately.

Verification
REQ-029 ICache read only, i_addr=0x100, mem_done 3 cycles after grant with data 0xDEADBEEF -> mem_rw_flag=01, mem_addr=0x100, i_busy 3 cycles, i_done one pulse, i_read_data=0xDEADBEEF.
REQ-030 Both request after reset (I read 0x200, D write 0x300 data 0x12345678 mask 1111) -> DCache served first (mem_rw_flag=10), then ICache; d_read_data unchanged.
REQ-031 Both held continuously for 4 transactions -> grants alternate D,I,D,I with one IDLE cycle between each.
REQ-032 rst=0 during SERVE_D with mem_done pending -> outputs at reset values same cycle, no d_done, next grant follows REQ-016 reset ordering.
REQ-033 mem_done pulse while IDLE and d_rw_flag=11 -> no state change, no done, mem_rw_flag stays 00.
